// File: rtl/matrix_cfg.sv
// matrix_cfg: runtime configuration controller for the data routing matrix.
//
// Reads command bytes from a host-side FIFO and edits a shadow copy of the
// routing LUT. A COMMIT copies the whole shadow onto the live LUT in one edge,
// so the matrix never sees a half-written table.
//
// Command byte: [7:6] opcode, [5:4] ignored, [3:0] row
//   00 NOP, 01 SET (next byte is the mask), 10 CLEAR shadow, 11 COMMIT
//
// Ports:
//   clk      master clock
//   rst_n    asynchronous active-low reset
//   cmd      FIFO output byte, valid while cmd_rdy=1
//   cmd_rdy  FIFO not-empty
//   cmd_pop  one-cycle pulse consuming the current byte
//   lut      live LUT, row r = lut[r*n +: n], bit t = forward to TX t
//   busy     high while a SET is in progress
//   err      sticky flag, set when a SET names a row >= m
//   err_clr  synchronous clear for err (a new error in the same cycle wins)
//   commits  number of COMMITs executed, wraps 255 -> 0
module matrix_cfg #(
    parameter int unsigned m = 8,  // RX ports (LUT rows), 1..16
    parameter int unsigned n = 8   // TX ports (bits per row), 1..8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     cmd,
    input  logic           cmd_rdy,
    output logic           cmd_pop,
    output logic [n*m-1:0] lut,
    output logic           busy,
    output logic           err,
    input  logic           err_clr,
    output logic [7:0]     commits
);

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StArg,
        StArgGap
    } state_e;

    localparam logic [1:0] OpNop    = 2'b00;
    localparam logic [1:0] OpSet    = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;
    localparam logic [1:0] OpCommit = 2'b11;

    state_e           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [7:0]       commits_q, commits_d;
    logic [n*m-1:0]   shadow_q, shadow_d;
    logic [n*m-1:0]   lut_q, lut_d;

    logic             pop;
    logic             set_err;
    logic             row_ok;

    // Five bits so that m = 16 still compares correctly.
    assign row_ok = ({1'b0, row_q} < 5'(m));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        busy_d    = busy_q;
        commits_d = commits_q;
        shadow_d  = shadow_q;
        lut_d     = lut_q;
        pop       = 1'b0;
        set_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    pop     = 1'b1;
                    state_d = StGap;
                    unique case (cmd[7:6])
                        OpNop: ;
                        OpSet: begin
                            row_d  = cmd[3:0];
                            busy_d = 1'b1;
                        end
                        OpClear: shadow_d = '0;
                        OpCommit: begin
                            lut_d     = shadow_q;
                            commits_d = commits_q + 8'd1;
                        end
                    endcase
                end
            end
            // The FIFO presents the next byte one cycle after a pop; busy_q
            // doubles as the "SET pending" marker here.
            StGap: state_d = busy_q ? StArg : StIdle;
            StArg: begin
                if (cmd_rdy) begin
                    pop     = 1'b1;
                    state_d = StArgGap;
                    if (row_ok) begin
                        for (int unsigned r = 0; r < m; r++) begin
                            if (row_q == 4'(r)) begin
                                shadow_d[r*n +: n] = cmd[n-1:0];
                            end
                        end
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            StArgGap: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= 4'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            commits_q <= 8'd0;
            shadow_q  <= '0;
            lut_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            commits_q <= commits_d;
            shadow_q  <= shadow_d;
            lut_q     <= lut_d;
        end
    end

    // Gated by rst_n so no byte is consumed while reset is held with a
    // non-empty FIFO.
    assign cmd_pop = pop & rst_n;
    assign lut     = lut_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign commits = commits_q;

endmodule

// File: tb/tb_matrix_cfg.sv
module tb_matrix_cfg;

    localparam int unsigned M = 8;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [7:0]     cmd;
    logic           cmd_rdy;
    logic           cmd_pop;
    logic [N*M-1:0] lut;
    logic           busy;
    logic           err;
    logic           err_clr;
    logic [7:0]     commits;

    matrix_cfg #(
        .m(M),
        .n(N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd),
        .cmd_rdy (cmd_rdy),
        .cmd_pop (cmd_pop),
        .lut     (lut),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr),
        .commits (commits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*M-1:0] lut;
        logic [7:0]     commits;
        logic           err;
        logic           busy;
        string          tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo[$];
    int         pop_cycle[$];
    int         checks = 0;
    int         passes = 0;
    int         cycle  = 0;

    // Reference model state.
    logic [N*M-1:0] m_shadow = '0;
    logic [N*M-1:0] m_lut    = '0;
    logic [7:0]     m_commits = 8'd0;
    logic           m_err    = 1'b0;
    logic           m_busy   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Queue a byte and the state expected right after the edge that pops it.
    task automatic push(input logic [7:0] b, input string tag);
        exp_t e;
        e.lut     = m_lut;
        e.commits = m_commits;
        e.err     = m_err;
        e.busy    = m_busy;
        e.tag     = tag;
        fifo.push_back(b);
        sb.push_back(e);
    endtask

    task automatic do_nop();
        push(8'h00, "nop");
    endtask

    task automatic set_hdr(input logic [3:0] row);
        m_busy = 1'b1;
        push({4'b0100, row}, "set_hdr");
    endtask

    task automatic set_arg(input logic [3:0] row, input logic [7:0] mask);
        if (int'(row) < M) m_shadow[int'(row)*N +: N] = mask[N-1:0];
        else m_err = 1'b1;
        push(mask, "set_arg");
        m_busy = 1'b0;
    endtask

    task automatic do_set(input logic [3:0] row, input logic [7:0] mask);
        set_hdr(row);
        set_arg(row, mask);
    endtask

    task automatic do_clear();
        m_shadow = '0;
        push(8'h80, "clear");
    endtask

    task automatic do_commit();
        m_lut     = m_shadow;
        m_commits = m_commits + 8'd1;
        push(8'hC0, "commit");
    endtask

    task automatic wait_sb();
        int i = 0;
        while ((fifo.size() != 0 || sb.size() != 0) && i < 400) begin
            @(posedge clk);
            #2;
            i++;
        end
        check("sb_timeout", 64'(i >= 400), 0);
    endtask

    task automatic drain();
        int i = 0;
        while ((fifo.size() != 0 || sb.size() != 0 || busy) && i < 1000) begin
            @(posedge clk);
            #2;
            i++;
        end
        check("drain_timeout", 64'(i >= 1000), 0);
        @(posedge clk);
        #2;
    endtask

    // FIFO model: front byte leaves just after the edge that popped it.
    initial begin
        logic popped;
        cmd     = 8'h00;
        cmd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            popped = cmd_pop;
            @(posedge clk);
            #1;
            if (popped && fifo.size() > 0) void'(fifo.pop_front());
            if (fifo.size() > 0) begin
                cmd     = fifo[0];
                cmd_rdy = 1'b1;
            end else begin
                cmd     = 8'h00;
                cmd_rdy = 1'b0;
            end
        end
    end

    // Monitor: each pop edge is compared against the next scoreboard entry.
    initial begin
        exp_t e;
        logic prev_pop;
        prev_pop = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (cmd_pop) begin
                check("pop_pacing", 64'(prev_pop), 0);
                pop_cycle.push_back(cycle);
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pop: got a pop, expected none");
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_lut"}, 64'(lut), 64'(e.lut));
                    check({e.tag, "_commits"}, 64'(commits), 64'(e.commits));
                    check({e.tag, "_err"}, 64'(err), 64'(e.err));
                    check({e.tag, "_busy"}, 64'(busy), 64'(e.busy));
                end
                prev_pop = 1'b1;
            end else begin
                prev_pop = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        err_clr = 1'b0;

        // Reset with a byte already waiting: nothing may be popped.
        do_nop();
        #20;
        check("rst_pop", 64'(cmd_pop), 0);
        check("rst_lut", 64'(lut), 0);
        check("rst_commits", 64'(commits), 0);
        check("rst_err", 64'(err), 0);
        check("rst_busy", 64'(busy), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain();

        // SET row 2 = 0x5, COMMIT.
        do_set(4'd2, 8'h05);
        do_commit();
        drain();
        check("t1_lut", 64'(lut), 64'h0000_0500);
        check("t1_commits", 64'(commits), 1);

        // Back-to-back stream: pops every second clock, 0xFF never reaches lut.
        pop_cycle.delete();
        do_set(4'd1, 8'hFF);
        do_clear();
        do_commit();
        drain();
        check("t2_npops", 64'(pop_cycle.size()), 4);
        for (int i = 0; i < 3 && i + 1 < pop_cycle.size(); i++) begin
            check("t2_pop_gap", 64'(pop_cycle[i+1] - pop_cycle[i]), 2);
        end
        check("t2_lut", 64'(lut), 0);
        check("t2_commits", 64'(commits), 2);

        // Out-of-range row, then clear one cycle later.
        do_set(4'd9, 8'h33);
        drain();
        check("t3_err_set", 64'(err), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("t3_err_clr", 64'(err), 0);
        err_clr = 1'b0;
        m_err   = 1'b0;

        // err_clr held through a new error: set wins on the error edge.
        err_clr = 1'b1;
        do_set(4'd9, 8'h33);
        drain();
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("t3_err_after_clr", 64'(err), 0);
        do_commit();
        drain();
        check("t3_no_alias", 64'(lut), 0);

        // Stall between SET header and mask.
        set_hdr(4'd3);
        wait_sb();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            check("t4_busy_stall", 64'(busy), 1);
        end
        set_arg(4'd3, 8'hA5);
        do_commit();
        drain();
        check("t4_lut", 64'(lut), 64'h0000_5000);
        check("t4_commits", 64'(commits), 4);

        // 256 COMMITs wrap the counter back to its start value.
        do_set(4'd0, 8'h0C);
        do_set(4'd7, 8'h09);
        for (int i = 0; i < 256; i++) do_commit();
        drain();
        check("t5_lut", 64'(lut), 64'h9000_500C);
        check("t5_commits_wrap", 64'(commits), 4);

        // Asynchronous reset mid-clock while waiting in ARG.
        set_hdr(4'd5);
        wait_sb();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_lut", 64'(lut), 0);
        check("t6_rst_commits", 64'(commits), 0);
        check("t6_rst_busy", 64'(busy), 0);
        check("t6_rst_err", 64'(err), 0);
        check("t6_rst_pop", 64'(cmd_pop), 0);
        m_shadow  = '0;
        m_lut     = '0;
        m_commits = 8'd0;
        m_err     = 1'b0;
        m_busy    = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_set(4'd7, 8'h09);
        do_commit();
        drain();
        check("t6_lut", 64'(lut), 64'h9000_0000);
        check("t6_commits", 64'(commits), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
